cellrv32_npu_load_sequencer: RTL and testbench

Upstream control stage for the NPU load counter. Accepts a buffer-load instruction (start address, length) over a valid/ready handshake and produces the counter's load, start-value and enable strobes. Emits a read-enable/last strobe train aligned with the counter's output, so the buffer read port sees exactly `len` consecutive addresses starting at `addr`. Reports busy/done to the NPU control unit.

---
 rtl/cellrv32_npu_load_sequencer_if.sv | 39 +++
 rtl/cellrv32_npu_load_sequencer.sv | 123 ++++++++++++
 tb/tb_cellrv32_npu_load_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cellrv32_npu_load_sequencer_if.sv
// rtl/cellrv32_npu_load_sequencer_if.sv - instruction, counter-control and read-strobe bundle of the NPU load sequencer
//
// Signals:
//   instr_valid_i/instr_ready_o/instr_addr_i/instr_len_i : buffer-load instruction handshake
//   cnt_load_o/cnt_start_val_o/cnt_enable_o              : load counter control
//   rd_en_o/last_o                                       : buffer read strobe train
//   busy_o/done_o/err_o                                  : status towards the NPU control unit
// Modports:
//   slave  : the sequencer side
//   master : the instruction issuer / observer side
interface cellrv32_npu_load_sequencer_if #(
    parameter int COUNTER_WIDTH = 32,
    parameter int LEN_WIDTH     = 16
);
    logic                     instr_valid_i;
    logic                     instr_ready_o;
    logic [COUNTER_WIDTH-1:0] instr_addr_i;
    logic [LEN_WIDTH-1:0]     instr_len_i;
    logic                     cnt_load_o;
    logic [COUNTER_WIDTH-1:0] cnt_start_val_o;
    logic                     cnt_enable_o;
    logic                     rd_en_o;
    logic                     last_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     err_o;

    modport slave (
        input  instr_valid_i, instr_addr_i, instr_len_i,
        output instr_ready_o, cnt_load_o, cnt_start_val_o, cnt_enable_o,
               rd_en_o, last_o, busy_o, done_o, err_o
    );

    modport master (
        output instr_valid_i, instr_addr_i, instr_len_i,
        input  instr_ready_o, cnt_load_o, cnt_start_val_o, cnt_enable_o,
               rd_en_o, last_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/cellrv32_npu_load_sequencer.sv
// rtl/cellrv32_npu_load_sequencer.sv - control stage driving the NPU load counter and the buffer read strobes
//
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : cellrv32_npu_load_sequencer_if.slave (instruction handshake, counter control,
//            read strobes, status)
// Optional feature macro: CELLRV32_NPU_LOAD_SEQ_BOUNDS_EN
//   defined   : instructions whose addr+len exceeds BUFFER_DEPTH are consumed and
//               answered with err_o + done_o, no load is performed
//   undefined : no bounds check, err_o is constant 0
module cellrv32_npu_load_sequencer #(
    parameter int COUNTER_WIDTH   = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int COUNTER_LATENCY = 3,
    parameter int BUFFER_DEPTH    = 4096
) (
    input  logic clk_i,
    input  logic rstn_i,
    cellrv32_npu_load_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                     state_q, state_d;
    logic [LEN_WIDTH-1:0]       rem_q, rem_d;
    logic [COUNTER_WIDTH-1:0]   start_val_q, start_val_d;
    logic [COUNTER_LATENCY-1:0] issue_pipe_q, issue_pipe_d;
    logic [COUNTER_LATENCY-1:0] last_pipe_q, last_pipe_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       issue;
    logic                       last_flag;
    logic                       bounds_err;

`ifdef CELLRV32_NPU_LOAD_SEQ_BOUNDS_EN
    logic [COUNTER_WIDTH:0] end_addr;
    assign end_addr   = {1'b0, bus.instr_addr_i} + (COUNTER_WIDTH+1)'(bus.instr_len_i);
    assign bounds_err = end_addr > (COUNTER_WIDTH+1)'(BUFFER_DEPTH);
`else
    assign bounds_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        start_val_d = start_val_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        issue       = 1'b0;
        last_flag   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid_i) begin
                    start_val_d = bus.instr_addr_i;
                    rem_d       = bus.instr_len_i;
                    if ((bus.instr_len_i == '0) || bounds_err) begin
                        done_d = 1'b1;
                        err_d  = bounds_err;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD, ST_RUN: begin
                issue     = 1'b1;
                rem_d     = rem_q - 1'b1;
                last_flag = (rem_q == LEN_WIDTH'(1));
                state_d   = last_flag ? ST_DRAIN : ST_RUN;
            end
            default: ;
        endcase

        // The pipe models the counter latency: a bit issued now reaches rd_en_o
        // in the same cycle the counter presents the matching address.
        issue_pipe_d = (issue_pipe_q << 1) | COUNTER_LATENCY'(issue);
        last_pipe_d  = (last_pipe_q  << 1) | COUNTER_LATENCY'(last_flag);

        // Leave DRAIN once the final strobe is on the output, so the first
        // IDLE cycle (with done_o) directly follows the last rd_en_o.
        if ((state_q == ST_DRAIN) && (issue_pipe_d == '0)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            start_val_q  <= '0;
            issue_pipe_q <= '0;
            last_pipe_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            start_val_q  <= start_val_d;
            issue_pipe_q <= issue_pipe_d;
            last_pipe_q  <= last_pipe_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.instr_ready_o   = (state_q == ST_IDLE);
    assign bus.busy_o          = (state_q != ST_IDLE);
    assign bus.cnt_enable_o    = (state_q != ST_IDLE);
    assign bus.cnt_load_o      = (state_q == ST_LOAD);
    assign bus.cnt_start_val_o = start_val_q;
    assign bus.rd_en_o         = issue_pipe_q[COUNTER_LATENCY-1];
    assign bus.last_o          = last_pipe_q[COUNTER_LATENCY-1];
    assign bus.done_o          = done_q;
    assign bus.err_o           = err_q;

endmodule

// File: tb/tb_cellrv32_npu_load_sequencer.sv
// tb/tb_cellrv32_npu_load_sequencer.sv - scoreboard bench for cellrv32_npu_load_sequencer
module tb_cellrv32_npu_load_sequencer;

    localparam int CW    = 32;
    localparam int LW    = 16;
    localparam int LAT   = 3;
    localparam int DEPTH = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    cellrv32_npu_load_sequencer_if #(.COUNTER_WIDTH(CW), .LEN_WIDTH(LW)) bus ();

    cellrv32_npu_load_sequencer #(
        .COUNTER_WIDTH  (CW),
        .LEN_WIDTH      (LW),
        .COUNTER_LATENCY(LAT),
        .BUFFER_DEPTH   (DEPTH)
    ) u_dut (
        .clk_i (clk),
        .rstn_i(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    int       exp_load_cyc[$];
    logic [CW-1:0] exp_load_val[$];
    int       exp_rd[$];
    int       exp_last[$];
    int       exp_done[$];
    int       exp_err[$];
    int       busy_from = 1;
    int       busy_to   = 0;
    bit       mon_en    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference model: from a handshake cycle t, derive every strobe the DUT owes.
    task automatic push_exp(input logic [CW-1:0] a, input logic [LW-1:0] l, input int t);
        bit       err;
        logic [CW:0] sum;
        sum = {1'b0, a} + {{(CW+1-LW){1'b0}}, l};
        err = 1'b0;
`ifdef CELLRV32_NPU_LOAD_SEQ_BOUNDS_EN
        err = (sum > DEPTH);
`endif
        if (l == 0 || err) begin
            exp_done.push_back(t + 1);
            if (err) exp_err.push_back(t + 1);
        end else begin
            exp_load_cyc.push_back(t + 1);
            exp_load_val.push_back(a);
            for (int k = 0; k < int'(l); k++) exp_rd.push_back(t + LAT + 1 + k);
            exp_last.push_back(t + LAT + int'(l));
            exp_done.push_back(t + LAT + 1 + int'(l));
            busy_from = t + 1;
            busy_to   = t + LAT + int'(l);
        end
    endtask

    task automatic send(input logic [CW-1:0] a, input logic [LW-1:0] l, output int t);
        bus.instr_valid_i = 1'b1;
        bus.instr_addr_i  = a;
        bus.instr_len_i   = l;
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.instr_ready_o) begin
                t = cyc;
                push_exp(a, l, t);
                break;
            end
        end
        if (t < 0) chk("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.instr_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic exp_busy;
            exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
            chk("busy", bus.busy_o, exp_busy);
            chk("ready", bus.instr_ready_o, !exp_busy);
            chk("enable", bus.cnt_enable_o, exp_busy);
            if (bus.cnt_load_o) begin
                if (exp_load_cyc.size() == 0) chk("load_unexpected", 1, 0);
                else begin
                    chk("load_cycle", cyc, exp_load_cyc.pop_front());
                    chk("load_val", bus.cnt_start_val_o, exp_load_val.pop_front());
                end
            end
            if (bus.rd_en_o) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_cycle", cyc, exp_rd.pop_front());
            end
            if (bus.last_o) begin
                chk("last_with_rd", bus.rd_en_o, 1);
                if (exp_last.size() == 0) chk("last_unexpected", 1, 0);
                else chk("last_cycle", cyc, exp_last.pop_front());
            end
            if (bus.done_o) begin
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, exp_done.pop_front());
            end
            if (bus.err_o) begin
                if (exp_err.size() == 0) chk("err_unexpected", 1, 0);
                else chk("err_cycle", cyc, exp_err.pop_front());
            end
        end
    end

    task automatic check_drained(input string tag);
        chk({tag, "_load_left"}, exp_load_cyc.size(), 0);
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        chk({tag, "_last_left"}, exp_last.size(), 0);
        chk({tag, "_done_left"}, exp_done.size(), 0);
        chk({tag, "_err_left"}, exp_err.size(), 0);
    endtask

    initial begin
        int t1;
        int t2;
        bus.instr_valid_i = 1'b0;
        bus.instr_addr_i  = '0;
        bus.instr_len_i   = '0;

        #1;
        chk("rst_ready", bus.instr_ready_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_rd", bus.rd_en_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_startval", bus.cnt_start_val_o, 0);
        idle(2);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(10);
        chk("idle_ready", bus.instr_ready_o, 1);
        chk("idle_load", bus.cnt_load_o, 0);
        chk("idle_err", bus.err_o, 0);

        // Directed cases
        send(32'h100, 16'd4, t1);
        idle(12);
        send(32'h0, 16'd1, t1);
        idle(8);
        send(32'h55, 16'd0, t1);
        idle(4);
        chk("startval_hold", bus.cnt_start_val_o, 32'h55);

        // Back-to-back: second instruction held valid while the first runs
        send(32'h200, 16'd3, t1);
        send(32'h300, 16'd2, t2);
        chk("b2b_accept_cycle", t2, t1 + 1 + LAT + 3);
        idle(12);
        check_drained("directed");

        // Bounds boundary: exactly fits, and overflows (only an error with the feature)
        send(32'd4086, 16'd10, t1);
        idle(20);
        send(32'd4090, 16'd10, t1);
        idle(20);
        check_drained("bounds");

        // Random lengths and addresses
        for (int i = 0; i < 12; i++) begin
            send(32'($urandom_range(0, 4095)), 16'($urandom_range(0, 9)), t1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        idle(20);
        check_drained("random");

        // Asynchronous reset in the middle of RUN
        send(32'h40, 16'd20, t1);
        idle(5);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_load", bus.cnt_load_o, 0);
        chk("arst_enable", bus.cnt_enable_o, 0);
        chk("arst_rd", bus.rd_en_o, 0);
        chk("arst_last", bus.last_o, 0);
        chk("arst_done", bus.done_o, 0);
        chk("arst_startval", bus.cnt_start_val_o, 0);
        chk("arst_ready", bus.instr_ready_o, 1);
        exp_load_cyc.delete();
        exp_load_val.delete();
        exp_rd.delete();
        exp_last.delete();
        exp_done.delete();
        exp_err.delete();
        busy_from = 1;
        busy_to   = 0;
        idle(3);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(30);
        send(32'h80, 16'd2, t1);
        idle(10);
        check_drained("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
